// File: rtl/dm_ctrl.sv
// dm_ctrl: MEM-stage data memory for the pipelined MIPS core.
// Byte/halfword/word stores, sign- or zero-extended loads, a req/ready
// handshake with READ_LAT cycles of read latency, alignment checking and a
// post-reset clear sweep.
// Optional feature: define DM_TRACE_EN to print committed stores and
// misaligned accesses via $display. The logic is identical either way.
module dm_ctrl #(
  parameter int ADDR_W         = 12,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        busy
);

  localparam int            WA    = ADDR_W - 2;
  localparam int            DEPTH = 1 << WA;
  localparam logic [WA-1:0] LAST  = {WA{1'b1}};
  localparam logic [2:0]    LAT   = 3'(READ_LAT);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RWAIT = 2'd2
  } state_t;

  state_t        state;
  logic [WA-1:0] ptr;
  logic [2:0]    cnt;
  logic [WA-1:0] ld_idx;
  logic [1:0]    ld_lane;
  logic [1:0]    ld_size;
  logic          ld_uns;
  logic          ld_err;

  logic [31:0]   mem [DEPTH];

  logic [WA-1:0] widx;
  logic          err;
  logic          accept;
  logic          st_ok;
  logic          clr_we;
  logic [31:0]   merged;

  // Bits outside the decoded window are ignored by design (addresses wrap);
  // pc is only consumed by the optional trace.
  logic unused_bits;
  assign unused_bits = &{1'b0, addr[31:ADDR_W], pc};

  // Misalignment: halfword on odd byte, word off a word boundary, reserved size.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
    logic r;
    case (sz)
      2'b00:   r = 1'b0;
      2'b01:   r = lane[0];
      2'b10:   r = (lane != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Merge right-aligned store data into the addressed lanes, keeping the rest.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00:   r[{lane, 3'b000} +: 8] = d[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = d[15:0];
      2'b10:   r = d;
      default: r = w;
    endcase
    return r;
  endfunction

  // Select the addressed lane of a word and sign/zero extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] lane, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = u ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = u ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   r = w;
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  assign widx   = addr[ADDR_W-1:2];
  assign err    = is_misaligned(size, addr[1:0]);
  assign accept = reset & ready & req;
  assign st_ok  = accept & we & ~err;
  assign clr_we = reset & (state == CLEAR);
  assign merged = store_merge(mem[widx], wdata, size, addr[1:0]);

  // Memory array: clear sweep writes and committed stores (optional trace).
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr] <= 32'h00000000;
    end else if (st_ok) begin
      mem[widx] <= merged;
    end
`ifdef DM_TRACE_EN
    if (st_ok) begin
      $display("%0t@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
    end
    if (accept && err) begin
      $display("%0t@%h: misalign %h", $time, pc, addr);
    end
`endif
  end

  // Control FSM with registered handshake, status and load result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      busy     <= (CLEAR_ON_RESET != 0);
      ready    <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= 32'h00000000;
      misalign <= 1'b0;
      ptr      <= '0;
      cnt      <= 3'd0;
      ld_idx   <= '0;
      ld_lane  <= 2'b00;
      ld_size  <= 2'b00;
      ld_uns   <= 1'b0;
      ld_err   <= 1'b0;
    end else begin
      rvalid   <= 1'b0;
      misalign <= 1'b0;
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else begin
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        IDLE: begin
          busy <= 1'b0;
          if (accept && !we) begin
            state   <= RWAIT;
            ready   <= 1'b0;
            cnt     <= 3'd1;
            ld_idx  <= widx;
            ld_lane <= addr[1:0];
            ld_size <= size;
            ld_uns  <= uns;
            ld_err  <= err;
          end else begin
            ready    <= 1'b1;
            misalign <= accept & we & err;
          end
        end
        RWAIT: begin
          if (cnt == LAT) begin
            state    <= IDLE;
            ready    <= 1'b1;
            rvalid   <= 1'b1;
            misalign <= ld_err;
            rdata    <= ld_err ? 32'h00000000 : load_ext(mem[ld_idx], ld_size, ld_lane, ld_uns);
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed self-checking bench for dm_ctrl (ADDR_W=6, READ_LAT=3, clear on reset).
module tb_dm_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        misalign;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  dm_ctrl #(.ADDR_W(6), .READ_LAT(3), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .pc(pc), .ready(ready), .rvalid(rvalid),
    .rdata(rdata), .misalign(misalign), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load: returns data, misalign at rvalid, latency, and whether ready stayed low while waiting.
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                         output logic [31:0] d, output logic m, output int lat,
                         output logic rdy_low, output logic rdy_at_valid);
    req = 1'b1; we = 1'b0; size = sz; uns = u; addr = a; pc = 32'h00001000;
    tick();
    req = 1'b0;
    lat = -1; rdy_low = 1'b1; d = 32'hxxxxxxxx; m = 1'bx; rdy_at_valid = 1'bx;
    if (ready !== 1'b0) rdy_low = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rvalid === 1'b1) begin
        lat = i; d = rdata; m = misalign; rdy_at_valid = ready;
        break;
      end
      if (ready !== 1'b0) rdy_low = 1'b0;
    end
  endtask

  // Store: returns misalign observed in the cycle after acceptance.
  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                          output logic m);
    req = 1'b1; we = 1'b1; size = sz; uns = 1'b0; addr = a; wdata = d; pc = 32'h00003008;
    tick();
    req = 1'b0; we = 1'b0;
    m = misalign;
  endtask

  // Count cycles after reset release until ready rises; busy must be high throughout.
  task automatic wait_sweep(output int n, output logic busy_ok);
    n = -1; busy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready === 1'b1) begin
        n = i;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    int n;
    logic bok;
    logic [31:0] d;
    logic m, rl, rv;
    int lat;
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0; pc = 32'h0;
    tick(); tick();
    total_cnt++;
    if ({ready, busy, rvalid, misalign} !== 4'b0100 || rdata !== 32'h0) begin
      $display("FAIL reset_outputs: ready/busy/rvalid/misalign=%b rdata=%h, expected 0100 rdata=0",
               {ready, busy, rvalid, misalign}, rdata);
    end else pass_cnt++;
    reset = 1'b1;
    wait_sweep(n, bok);
    total_cnt++;
    if (n !== 16) $display("FAIL sweep_len: got %0d cycles, expected 16", n);
    else pass_cnt++;
    total_cnt++;
    if (bok !== 1'b1 || busy !== 1'b0) $display("FAIL sweep_busy: busy_ok=%b busy_after=%b, expected 1/0", bok, busy);
    else pass_cnt++;
    do_load(32'h3C, 2'b10, 1'b0, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'h0 || lat !== 3) $display("FAIL clear_load: rdata=%h lat=%0d, expected 00000000 lat=3", d, lat);
    else pass_cnt++;
  endtask

  task automatic test_store_load();
    logic [31:0] d;
    logic m, rl, rv;
    int lat;
    do_store(32'h10, 2'b10, 32'hDEADBEEF, m);
    do_store(32'h12, 2'b00, 32'h00000011, m);
    do_load(32'h10, 2'b10, 1'b0, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'hDE11BEEF) $display("FAIL word_load: rdata=%h, expected DE11BEEF", d);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 3 || rl !== 1'b1 || rv !== 1'b1)
      $display("FAIL load_handshake: lat=%0d ready_low=%b ready_at_rvalid=%b, expected 3/1/1", lat, rl, rv);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rvalid !== 1'b0 || rdata !== 32'hDE11BEEF)
      $display("FAIL rdata_hold: rvalid=%b rdata=%h, expected 0 DE11BEEF", rvalid, rdata);
    else pass_cnt++;
  endtask

  task automatic test_extend();
    logic [31:0] d;
    logic m, rl, rv;
    int lat;
    do_load(32'h13, 2'b00, 1'b0, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'hFFFFFFDE) $display("FAIL lb: rdata=%h, expected FFFFFFDE", d);
    else pass_cnt++;
    do_load(32'h13, 2'b00, 1'b1, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'h000000DE) $display("FAIL lbu: rdata=%h, expected 000000DE", d);
    else pass_cnt++;
    do_load(32'h10, 2'b01, 1'b0, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'hFFFFBEEF) $display("FAIL lh: rdata=%h, expected FFFFBEEF", d);
    else pass_cnt++;
    do_load(32'h12, 2'b01, 1'b1, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'h0000DE11) $display("FAIL lhu: rdata=%h, expected 0000DE11", d);
    else pass_cnt++;
    do_load(32'h10, 2'b10, 1'b1, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'hDE11BEEF) $display("FAIL lw_ignores_uns: rdata=%h, expected DE11BEEF", d);
    else pass_cnt++;
    do_load(32'hFFFF_FF50, 2'b10, 1'b0, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'hDE11BEEF) $display("FAIL addr_wrap: rdata=%h, expected DE11BEEF", d);
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    logic [31:0] d;
    logic m, rl, rv;
    int lat;
    do_store(32'h06, 2'b10, 32'h12345678, m);
    total_cnt++;
    if (m !== 1'b1) $display("FAIL st_misalign_pulse: misalign=%b, expected 1", m);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (misalign !== 1'b0) $display("FAIL st_misalign_one_cycle: misalign=%b, expected 0", misalign);
    else pass_cnt++;
    do_load(32'h04, 2'b10, 1'b0, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'h0 || m !== 1'b0) $display("FAIL st_misalign_nowrite: rdata=%h misalign=%b, expected 0/0", d, m);
    else pass_cnt++;
    do_load(32'h05, 2'b01, 1'b0, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'h0 || m !== 1'b1 || lat !== 3)
      $display("FAIL ld_misalign: rdata=%h misalign=%b lat=%0d, expected 0/1/3", d, m, lat);
    else pass_cnt++;
    do_load(32'h10, 2'b11, 1'b0, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'h0 || m !== 1'b1) $display("FAIL ld_reserved_size: rdata=%h misalign=%b, expected 0/1", d, m);
    else pass_cnt++;
    do_store(32'h11, 2'b00, 32'h000000FF, m);
    total_cnt++;
    if (m !== 1'b0) $display("FAIL byte_store_aligned: misalign=%b, expected 0", m);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic m, rl, rv;
    int lat;
    logic rdy_ok;
    rdy_ok = 1'b1;
    req = 1'b1; we = 1'b1; pc = 32'h00003010;
    size = 2'b00; addr = 32'h20; wdata = 32'h000000AA; tick();
    if (ready !== 1'b1) rdy_ok = 1'b0;
    size = 2'b00; addr = 32'h21; wdata = 32'h000000BB; tick();
    if (ready !== 1'b1) rdy_ok = 1'b0;
    size = 2'b01; addr = 32'h22; wdata = 32'h0000CCDD; tick();
    if (ready !== 1'b1) rdy_ok = 1'b0;
    req = 1'b0; we = 1'b0;
    total_cnt++;
    if (rdy_ok !== 1'b1) $display("FAIL b2b_ready: ready dropped during store burst, expected 1");
    else pass_cnt++;
    do_load(32'h20, 2'b10, 1'b0, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'hCCDDBBAA) $display("FAIL b2b_data: rdata=%h, expected CCDDBBAA", d);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    logic m, rl, rv;
    int lat, n;
    logic bok, saw_rvalid;
    do_store(32'h08, 2'b10, 32'h00000055, m);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h08;
    tick();
    req = 1'b0;
    saw_rvalid = 1'b0;
    reset = 1'b0;
    tick();
    if (rvalid === 1'b1) saw_rvalid = 1'b1;
    reset = 1'b1;
    total_cnt++;
    if (busy !== 1'b1 || ready !== 1'b0) $display("FAIL abort_state: busy=%b ready=%b, expected 1/0", busy, ready);
    else pass_cnt++;
    n = -1; bok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rvalid === 1'b1) saw_rvalid = 1'b1;
      if (ready === 1'b1) begin
        n = i;
        break;
      end
      if (busy !== 1'b1) bok = 1'b0;
    end
    total_cnt++;
    if (saw_rvalid !== 1'b0) $display("FAIL abort_no_rvalid: rvalid seen=%b, expected 0", saw_rvalid);
    else pass_cnt++;
    total_cnt++;
    if (n !== 16 || bok !== 1'b1) $display("FAIL abort_sweep: cycles=%0d busy_ok=%b, expected 16/1", n, bok);
    else pass_cnt++;
    do_load(32'h08, 2'b10, 1'b0, d, m, lat, rl, rv);
    total_cnt++;
    if (d !== 32'h0 || lat !== 3) $display("FAIL abort_cleared: rdata=%h lat=%0d, expected 00000000/3", d, lat);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extend();
    test_misalign();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
